// File: rtl/maze_round_ctrl_if.sv
// ---------------------------------------------------------------------------
// maze_round_ctrl_if
//   Signal bundle between the maze round sequencer and the rest of the game.
//   slave  : sequencer view (buttons/goal/time in, maze reset + status out)
//   master : surrounding logic view (drives the inputs, reads the status)
//   Signals:
//     iSTART_N  start/restart pushbutton, active-low, asynchronous
//     iGOAL     player at exit, synchronous level
//     iTIME_BCD round length, two BCD digits
//     iPAUSE_N  pause pushbutton, active-low (only with MAZE_ROUND_PAUSE_EN)
//     oMAZE_RST active-high maze block reset
//     oSEC_BCD  remaining seconds, BCD
//     oRUN / oWIN / oTIMEOUT  status LEDs
//     oSTATE    IDLE=0, CLEAR=1, PLAY=2, WIN=3, LOSE=4
// ---------------------------------------------------------------------------
interface maze_round_ctrl_if;
    logic       iSTART_N;
    logic       iGOAL;
    logic [7:0] iTIME_BCD;
`ifdef MAZE_ROUND_PAUSE_EN
    logic       iPAUSE_N;
`endif
    logic       oMAZE_RST;
    logic [7:0] oSEC_BCD;
    logic       oRUN;
    logic       oWIN;
    logic       oTIMEOUT;
    logic [2:0] oSTATE;

    modport slave (
`ifdef MAZE_ROUND_PAUSE_EN
        input  iPAUSE_N,
`endif
        input  iSTART_N,
        input  iGOAL,
        input  iTIME_BCD,
        output oMAZE_RST,
        output oSEC_BCD,
        output oRUN,
        output oWIN,
        output oTIMEOUT,
        output oSTATE
    );

    modport master (
`ifdef MAZE_ROUND_PAUSE_EN
        output iPAUSE_N,
`endif
        output iSTART_N,
        output iGOAL,
        output iTIME_BCD,
        input  oMAZE_RST,
        input  oSEC_BCD,
        input  oRUN,
        input  oWIN,
        input  oTIMEOUT,
        input  oSTATE
    );
endinterface

// File: rtl/maze_round_ctrl.sv
// ---------------------------------------------------------------------------
// maze_round_ctrl
//   Round sequencer for the maze game: owns the maze reset, the BCD round
//   countdown and the start pushbutton; ends a round on goal (WIN) or on
//   the countdown reaching zero (LOSE).
//   Ports:
//     iCLK    system clock
//     iRST_N  synchronous active-low reset
//     bus     maze_round_ctrl_if.slave (buttons, goal, time in; status out)
//   Parameters:
//     CLK_HZ        clock cycles per countdown second
//     MAZE_RST_CYC  cycles the maze reset is held in CLEAR (>= 1)
//     DEFAULT_TIME  BCD round length used for an invalid or zero iTIME_BCD
//   Optional feature: define MAZE_ROUND_PAUSE_EN to add the iPAUSE_N
//   pushbutton, which toggles a pause of the countdown while in PLAY.
// ---------------------------------------------------------------------------
module maze_round_ctrl #(
    parameter int         CLK_HZ       = 50000000,
    parameter int         MAZE_RST_CYC = 16,
    parameter logic [7:0] DEFAULT_TIME = 8'h60
) (
    input logic              iCLK,
    input logic              iRST_N,
    maze_round_ctrl_if.slave bus
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int CW = (MAZE_RST_CYC > 1) ? $clog2(MAZE_RST_CYC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
    localparam logic [CW-1:0] CLR_INIT  = CW'(MAZE_RST_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_PLAY  = 3'd2,
        S_WIN   = 3'd3,
        S_LOSE  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    secs_q, secs_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [CW-1:0] clr_cnt_q, clr_cnt_d;
    logic          start_sync1_q, start_sync1_d;
    logic          start_sync2_q, start_sync2_d;
    logic          start_edge_q, start_edge_d;
    logic          maze_rst_q, maze_rst_d;
    logic          run_q, run_d;
    logic          win_q, win_d;
    logic          timeout_q, timeout_d;

    logic          start_pulse;
    logic          tick;
    logic          play_hold;
    logic [7:0]    load_secs;

`ifdef MAZE_ROUND_PAUSE_EN
    logic          pause_sync1_q, pause_sync1_d;
    logic          pause_sync2_q, pause_sync2_d;
    logic          pause_edge_q, pause_edge_d;
    logic          paused_q, paused_d;
    logic          pause_pulse;
`endif

    // BCD decrement, saturating at 00.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h00) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd0) begin
            r = {v[7:4] - 4'd1, 4'd9};
        end else begin
            r = {v[7:4], v[3:0] - 4'd1};
        end
        return r;
    endfunction

    always_comb begin
        // Synchronizer chain and edge register for the pushbutton(s).
        start_sync1_d = bus.iSTART_N;
        start_sync2_d = start_sync1_q;
        start_edge_d  = start_sync2_q;
        start_pulse   = ~start_sync2_q & start_edge_q;

`ifdef MAZE_ROUND_PAUSE_EN
        pause_sync1_d = bus.iPAUSE_N;
        pause_sync2_d = pause_sync1_q;
        pause_edge_d  = pause_sync2_q;
        pause_pulse   = ~pause_sync2_q & pause_edge_q;
        play_hold     = paused_q;
`else
        play_hold     = 1'b0;
`endif

        tick = (presc_q == PRESC_MAX);

        if ((bus.iTIME_BCD[7:4] > 4'd9) || (bus.iTIME_BCD[3:0] > 4'd9) ||
            (bus.iTIME_BCD == 8'h00)) begin
            load_secs = DEFAULT_TIME;
        end else begin
            load_secs = bus.iTIME_BCD;
        end

        state_d   = state_q;
        secs_d    = secs_q;
        presc_d   = presc_q;
        clr_cnt_d = clr_cnt_q;

        case (state_q)
            S_IDLE: ;
            S_CLEAR: begin
                if (clr_cnt_q == '0) begin
                    state_d = S_PLAY;
                    presc_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q - CW'(1);
                end
            end
            S_PLAY: begin
                if (!play_hold) begin
                    if (bus.iGOAL) begin
                        state_d = S_WIN;
                    end else if (tick) begin
                        presc_d = '0;
                        if (secs_q == 8'h01) begin
                            secs_d  = 8'h00;
                            state_d = S_LOSE;
                        end else begin
                            secs_d = bcd_dec(secs_q);
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
            end
            S_WIN:  ;
            S_LOSE: ;
            default: state_d = S_IDLE;
        endcase

        // Start has top priority in every state, so it is applied as a
        // final override instead of being repeated in each case arm.
        if (start_pulse) begin
            state_d   = S_CLEAR;
            secs_d    = load_secs;
            clr_cnt_d = CLR_INIT;
        end

`ifdef MAZE_ROUND_PAUSE_EN
        paused_d = paused_q;
        if ((state_q == S_PLAY) && pause_pulse) begin
            paused_d = ~paused_q;
        end
        if ((state_d != S_PLAY) || start_pulse) begin
            paused_d = 1'b0;
        end
        run_d = (state_d == S_PLAY) && !paused_d;
`else
        run_d = (state_d == S_PLAY);
`endif

        maze_rst_d = (state_d == S_IDLE) || (state_d == S_CLEAR) ||
                     (state_d == S_LOSE);
        win_d      = (state_d == S_WIN);
        timeout_d  = (state_d == S_LOSE);
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state_q       <= S_IDLE;
            secs_q        <= 8'h00;
            presc_q       <= '0;
            clr_cnt_q     <= '0;
            start_sync1_q <= 1'b1;
            start_sync2_q <= 1'b1;
            start_edge_q  <= 1'b1;
            maze_rst_q    <= 1'b1;
            run_q         <= 1'b0;
            win_q         <= 1'b0;
            timeout_q     <= 1'b0;
`ifdef MAZE_ROUND_PAUSE_EN
            pause_sync1_q <= 1'b1;
            pause_sync2_q <= 1'b1;
            pause_edge_q  <= 1'b1;
            paused_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            secs_q        <= secs_d;
            presc_q       <= presc_d;
            clr_cnt_q     <= clr_cnt_d;
            start_sync1_q <= start_sync1_d;
            start_sync2_q <= start_sync2_d;
            start_edge_q  <= start_edge_d;
            maze_rst_q    <= maze_rst_d;
            run_q         <= run_d;
            win_q         <= win_d;
            timeout_q     <= timeout_d;
`ifdef MAZE_ROUND_PAUSE_EN
            pause_sync1_q <= pause_sync1_d;
            pause_sync2_q <= pause_sync2_d;
            pause_edge_q  <= pause_edge_d;
            paused_q      <= paused_d;
`endif
        end
    end

    assign bus.oMAZE_RST = maze_rst_q;
    assign bus.oSEC_BCD  = secs_q;
    assign bus.oRUN      = run_q;
    assign bus.oWIN      = win_q;
    assign bus.oTIMEOUT  = timeout_q;
    assign bus.oSTATE    = state_q;

endmodule
